output_serializer: RTL

Parametrised successor to the engine's output interface. It accepts completed ciphertext blocks from the AES transformer into a small block FIFO. It then serialises each block MSB-first onto an OUT_W-bit stream with valid/ready backpressure, a last-word flag and back-to-back blocks with no bubble. It sits between the AES core and the external byte/word sink.

---
 rtl/aes_io_pkg.sv | 25 ++
 rtl/block_fifo.sv | 71 +++++++
 rtl/output_serializer.sv | 137 +++++++++++++
 3 files changed

// File: rtl/aes_io_pkg.sv
// Shared definitions for the AES output path.
//   - Default block / output word widths.
//   - Output FSM state type.
//   - Helpers deriving words-per-block and the word index width.
package aes_io_pkg;

  localparam int unsigned DefBlockW = 128;
  localparam int unsigned DefOutW   = 8;

  typedef enum logic {
    StIdle,
    StSend
  } out_state_e;

  function automatic int unsigned calc_nwords(input int unsigned block_w,
                                              input int unsigned out_w);
    return block_w / out_w;
  endfunction

  function automatic int unsigned calc_idx_w(input int unsigned block_w,
                                             input int unsigned out_w);
    return $clog2(calc_nwords(block_w, out_w));
  endfunction

endpackage

// File: rtl/block_fifo.sv
// Small synchronous block FIFO.
// Ports:
//   clk, rst_       clock, synchronous active-high reset
//   push, wdata     write request and data (ignored when full without a pop)
//   pop             remove the head (ignored when empty)
//   head            oldest entry, valid when !empty
//   next            entry behind the head, valid when count >= 2
//   count           number of stored entries
//   full, empty     status flags derived from count
module block_fifo #(
  parameter int unsigned WIDTH = 128,
  parameter int unsigned DEPTH = 2,
  localparam int unsigned CntW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [WIDTH-1:0] next,
  output logic [CntW-1:0]  count,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q;
  logic             push_ok, pop_ok;

  // Wrap explicitly so non-power-of-two depths work.
  function automatic logic [PtrW-1:0] ptr_incr(input logic [PtrW-1:0] p);
    return (p == PtrW'(DEPTH - 1)) ? '0 : p + PtrW'(1);
  endfunction

  assign empty   = (count_q == '0);
  assign full    = (count_q == CntW'(DEPTH));
  assign count   = count_q;
  assign pop_ok  = pop & ~empty;
  // A push into a full FIFO is legal when the head leaves on the same edge.
  assign push_ok = push & (~full | pop_ok);

  assign head = mem_q[rd_ptr_q];
  assign next = mem_q[ptr_incr(rd_ptr_q)];

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= ptr_incr(wr_ptr_q);
      if (pop_ok)  rd_ptr_q <= ptr_incr(rd_ptr_q);
      unique case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + CntW'(1);
        2'b01:   count_q <= count_q - CntW'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/output_serializer.sv
// Buffers completed ciphertext blocks and streams them MSB-first as OUT_W-bit words.
// Ports:
//   clk, rst_         clock, synchronous active-high reset
//   transformer_done  rising edge requests capture of ciphertext
//   ciphertext        block data, held stable until output_read
//   output_read       one-cycle pulse: block captured
//   data_out          current output word
//   data_ok           data_out valid
//   data_ready        sink accepts the word this cycle
//   data_last         data_out is the final word of its block
//   full              FIFO holds DEPTH blocks
//   busy              work buffered, in flight or pending
module output_serializer
  import aes_io_pkg::*;
#(
  parameter int unsigned BLOCK_W = DefBlockW,
  parameter int unsigned OUT_W   = DefOutW,
  parameter int unsigned DEPTH   = 2
) (
  input  logic               clk,
  input  logic               rst_,
  input  logic               transformer_done,
  input  logic [BLOCK_W-1:0] ciphertext,
  output logic               output_read,
  output logic [OUT_W-1:0]   data_out,
  output logic               data_ok,
  input  logic               data_ready,
  output logic               data_last,
  output logic               full,
  output logic               busy
);

  localparam int unsigned NWords = calc_nwords(BLOCK_W, OUT_W);
  localparam int unsigned IdxW   = calc_idx_w(BLOCK_W, OUT_W);
  localparam int unsigned CntW   = $clog2(DEPTH + 1);

  logic               done_q, armed_q, pending_q, output_read_q;
  out_state_e         state_q;
  logic [BLOCK_W-1:0] shreg_q;
  logic [IdxW-1:0]    idx_q;
  logic               data_ok_q, data_last_q;

  logic               fifo_full, fifo_empty, fifo_more;
  logic [CntW-1:0]    fifo_count;
  logic [BLOCK_W-1:0] fifo_head, fifo_next;
  logic               rise, xfer, last_word, pop, capture;

  // armed_q blocks a level held high across reset from looking like a new request.
  assign rise      = transformer_done & ~done_q & armed_q;
  assign xfer      = data_ok_q & data_ready;
  assign last_word = (idx_q == IdxW'(NWords - 1));
  assign pop       = xfer & last_word;
  assign capture   = pending_q & (~fifo_full | pop);
  // Uses the pre-edge count, so a block captured on this edge is not seen yet.
  assign fifo_more = 32'(fifo_count) > 32'd1;

  block_fifo #(
    .WIDTH(BLOCK_W),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst_ (rst_),
    .push (capture),
    .wdata(ciphertext),
    .pop  (pop),
    .head (fifo_head),
    .next (fifo_next),
    .count(fifo_count),
    .full (fifo_full),
    .empty(fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (rst_) begin
      done_q        <= 1'b0;
      armed_q       <= ~transformer_done;
      pending_q     <= 1'b0;
      output_read_q <= 1'b0;
    end else begin
      done_q        <= transformer_done;
      armed_q       <= armed_q | ~transformer_done;
      // A rise while pending is absorbed; a rise on the capture edge starts a new request.
      pending_q     <= (pending_q & ~capture) | rise;
      output_read_q <= capture;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_) begin
      state_q     <= StIdle;
      shreg_q     <= '0;
      idx_q       <= '0;
      data_ok_q   <= 1'b0;
      data_last_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (!fifo_empty) begin
            shreg_q     <= fifo_head;
            idx_q       <= '0;
            data_ok_q   <= 1'b1;
            data_last_q <= 1'b0;
            state_q     <= StSend;
          end
        end
        StSend: begin
          if (xfer) begin
            if (last_word) begin
              data_last_q <= 1'b0;
              if (fifo_more) begin
                // Head pops on this edge; the entry behind it streams next with no gap.
                shreg_q <= fifo_next;
                idx_q   <= '0;
              end else begin
                data_ok_q <= 1'b0;
                state_q   <= StIdle;
              end
            end else begin
              shreg_q     <= shreg_q << OUT_W;
              idx_q       <= idx_q + IdxW'(1);
              data_last_q <= (idx_q == IdxW'(NWords - 2));
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign output_read = output_read_q;
  assign data_out    = shreg_q[BLOCK_W-1 -: OUT_W];
  assign data_ok     = data_ok_q;
  assign data_last   = data_last_q;
  assign full        = fifo_full;
  assign busy        = ~fifo_empty | data_ok_q | pending_q;

endmodule
